step_sched: RTL

- Round-robin scheduler that shares one step accumulator (4-bit add/subtract datapath, ctrl selects direction) between NREQ requesters.
- Arbitrates requests, latches the winner's step and direction, and issues one operation at a time over a valid/ready handshake.
- Keeps a mirror of the accumulator value and flags wrap-around.
- Sits between client logic and the accumulator instance.

---
 rtl/step_sched_pkg.sv | 41 ++++
 rtl/step_sched_if.sv | 27 ++
 rtl/step_sched_rr_pick.sv | 25 ++
 rtl/step_sched.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/step_sched_pkg.sv
// rtl/step_sched_pkg.sv - shared types and rotate-priority helper for step_sched
package step_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic DIR_ADD = 1'b0;
    localparam logic DIR_SUB = 1'b1;

    // Requester indices are carried at a fixed width wide enough for up to 8 requesters
    localparam int IDX_W   = 3;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request at or above ptr, wrapping modulo nreq
    function automatic pick_t rr_select(input logic [MAX_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 nreq);
        pick_t          res;
        logic [IDX_W:0] j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = {1'b0, ptr} + (IDX_W+1)'(k);
            if (j >= (IDX_W+1)'(nreq)) begin
                j = j - (IDX_W+1)'(nreq);
            end
            if ((k < nreq) && !res.found && req[j[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/step_sched_if.sv
// rtl/step_sched_if.sv - requester and accumulator signal bundle for step_sched
interface step_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*WIDTH-1:0] req_step;
    logic [NREQ-1:0]       gnt;
    logic                  acc_valid;
    logic                  acc_ctrl;
    logic [WIDTH-1:0]      acc_step;
    logic                  acc_ready;
    logic [WIDTH-1:0]      acc_mirror;
    logic                  wrap;
    logic                  busy;

    modport master (
        output req, req_dir, req_step, acc_ready,
        input  gnt, acc_valid, acc_ctrl, acc_step, acc_mirror, wrap, busy
    );

    modport slave (
        input  req, req_dir, req_step, acc_ready,
        output gnt, acc_valid, acc_ctrl, acc_step, acc_mirror, wrap, busy
    );
endinterface

// File: rtl/step_sched_rr_pick.sv
// rtl/step_sched_rr_pick.sv - combinational rotate-priority select over NREQ requesters
module rr_pick
    import step_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_REQ-1:0] req_pad;
    pick_t              pick;

    // Zero-extend the request vector and search upward from ptr
    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req;
        pick               = rr_select(req_pad, ptr, NREQ);
        found              = pick.found;
        idx                = pick.idx;
    end

endmodule

// File: rtl/step_sched.sv
// rtl/step_sched.sv - round-robin scheduler feeding one add/subtract step accumulator
module step_sched
    import step_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int MAXBURST = 2
) (
    input  logic         clk,
    input  logic         rst,
    step_sched_if.slave  bus
);

    localparam logic [7:0] MAXB = 8'(MAXBURST);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         burst_q, burst_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic               ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   mirror_q, mirror_d;
    logic               wrap_q, wrap_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;

    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] dir_pad;
    logic [WIDTH-1:0]   step_arr [MAX_REQ];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH:0]     sum_ext;
    logic               handshake;
    logic               burst_more;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Spread the per-requester buses into fixed-size tables indexed by requester number
    always_comb begin
        req_pad = '0;
        dir_pad = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            step_arr[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            req_pad[i]  = bus.req[i];
            dir_pad[i]  = bus.req_dir[i];
            step_arr[i] = bus.req_step[i*WIDTH +: WIDTH];
        end
    end

    // Mirror adder; the extra top bit is the carry (add) or borrow (subtract)
    always_comb begin
        if (ctrl_q == DIR_ADD) begin
            sum_ext = {1'b0, mirror_q} + {1'b0, step_q};
        end else begin
            sum_ext = {1'b0, mirror_q} - {1'b0, step_q};
        end
    end

    assign handshake  = (state_q == ISSUE) && bus.acc_ready;
    assign burst_more = req_pad[owner_q] && ((burst_q + 8'd1) < MAXB);

    // Next-state: arbitrate in IDLE, retire and optionally continue a burst in ISSUE
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        step_d   = step_q;
        ctrl_d   = ctrl_q;
        mirror_d = mirror_q;
        wrap_d   = 1'b0;
        gnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = ISSUE;
                    owner_d = pick_idx;
                    burst_d = '0;
                    step_d  = step_arr[pick_idx];
                    ctrl_d  = dir_pad[pick_idx];
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (pick_idx == IDX_W'(i));
                    end
                end
            end
            ISSUE: begin
                if (handshake) begin
                    mirror_d = sum_ext[WIDTH-1:0];
                    wrap_d   = sum_ext[WIDTH];
                    if (burst_more) begin
                        burst_d = burst_q + 8'd1;
                        step_d  = step_arr[owner_q];
                        ctrl_d  = dir_pad[owner_q];
                        for (int i = 0; i < NREQ; i++) begin
                            gnt_d[i] = (owner_q == IDX_W'(i));
                        end
                    end else begin
                        state_d = IDLE;
                        ptr_d   = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; asynchronous reset discards any pending operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
            step_q   <= '0;
            ctrl_q   <= 1'b0;
            mirror_q <= '0;
            wrap_q   <= 1'b0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            step_q   <= step_d;
            ctrl_q   <= ctrl_d;
            mirror_q <= mirror_d;
            wrap_q   <= wrap_d;
            gnt_q    <= gnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.acc_valid  = (state_q == ISSUE);
    assign bus.acc_ctrl   = ctrl_q;
    assign bus.acc_step   = step_q;
    assign bus.acc_mirror = mirror_q;
    assign bus.wrap       = wrap_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
